// File: rtl/bcd_digit_serializer_if.sv
// Digit stream from the BCD serializer to the OLED glyph renderer.
// The serializer drives the digit side (master); the renderer drives ready (slave).
interface bcd_digit_serializer_if #(
    parameter int DIGITS_NUM = 6
);
    localparam int IDX_W = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;

    logic [3:0]       digit_out;
    logic [IDX_W-1:0] digit_index_out;
    logic             digit_valid_out;
    logic             digit_ready_in;
    logic             last_out;

    modport master (
        output digit_out,
        output digit_index_out,
        output digit_valid_out,
        output last_out,
        input  digit_ready_in
    );

    modport slave (
        input  digit_out,
        input  digit_index_out,
        input  digit_valid_out,
        input  last_out,
        output digit_ready_in
    );
endinterface

// File: rtl/bcd_digit_serializer.sv
// Snapshots a packed BCD value plus overflow on start and streams its digits,
// most significant first, with optional leading-zero and overflow substitution.
module bcd_digit_serializer #(
    parameter int         DIGITS_NUM          = 6,
    parameter bit         BLANK_LEADING_ZEROS = 1'b1,
    parameter logic [3:0] BLANK_CODE          = 4'hF,
    parameter logic [3:0] OVF_CODE            = 4'hE
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    start_in,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    input  logic                    overflow_in,
    bcd_digit_serializer_if.master  stream,
    output logic                    busy_out,
    output logic                    done_out
);
    localparam int IDX_W = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DIGITS_NUM - 1);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             ovf_reg, ovf_next;
    logic             seen_reg, seen_next;
    logic [3:0]       digit_reg, digit_next;
    logic             valid_reg, valid_next;
    logic             last_reg, last_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [3:0]       snap_reg [DIGITS_NUM];
    logic             capture;
    logic [IDX_W-1:0] idx_dec;
    logic [3:0]       top_in;
    logic [3:0]       nxt_raw;

    // seen = a nonzero digit has already been presented in this stream, so
    // "this and all higher digits are zero" reduces to !seen && digit == 0.
    function automatic logic [3:0] glyph(input logic [3:0] d, input logic seen,
                                         input logic at_zero, input logic ovf);
        if (ovf)
            return OVF_CODE;
        else if (BLANK_LEADING_ZEROS && !at_zero && !seen && d == 4'd0)
            return BLANK_CODE;
        else
            return d;
    endfunction

    assign capture = (state_reg == IDLE) && start_in;
    assign idx_dec = idx_reg - 1'b1;
    assign top_in  = digits_in[4*DIGITS_NUM-1 -: 4];
    assign nxt_raw = snap_reg[idx_dec];

    generate
        for (genvar gi = 0; gi < DIGITS_NUM; gi++) begin : g_snap
            always_ff @(posedge clk_in) begin
                if (reset_in)
                    snap_reg[gi] <= 4'd0;
                else if (capture)
                    snap_reg[gi] <= digits_in[4*gi +: 4];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ovf_next   = ovf_reg;
        seen_next  = seen_reg;
        digit_next = digit_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (start_in) begin
                    state_next = EMIT;
                    idx_next   = TOP_IDX;
                    ovf_next   = overflow_in;
                    digit_next = glyph(top_in, 1'b0, TOP_IDX == '0, overflow_in);
                    seen_next  = (top_in != 4'd0);
                    valid_next = 1'b1;
                    last_next  = (TOP_IDX == '0);
                    busy_next  = 1'b1;
                end
            end
            EMIT: begin
                if (stream.digit_ready_in) begin
                    if (idx_reg == '0) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next   = idx_dec;
                        digit_next = glyph(nxt_raw, seen_reg, idx_dec == '0, ovf_reg);
                        seen_next  = seen_reg | (nxt_raw != 4'd0);
                        last_next  = (idx_dec == '0);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            ovf_reg   <= 1'b0;
            seen_reg  <= 1'b0;
            digit_reg <= 4'd0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            ovf_reg   <= ovf_next;
            seen_reg  <= seen_next;
            digit_reg <= digit_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign stream.digit_out       = digit_reg;
    assign stream.digit_index_out = idx_reg;
    assign stream.digit_valid_out = valid_reg;
    assign stream.last_out        = last_reg;
    assign busy_out               = busy_reg;
    assign done_out               = done_reg;
endmodule

// File: tb/tb_bcd_digit_serializer.sv
// Directed and random streams for two serializers (blanking on and off) fed
// the same inputs, checked against a digit-by-digit arithmetic reference.
module tb_bcd_digit_serializer;
    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [23:0]   digits;
    logic          ovf;
    logic          ready;
    logic          busy_a, done_a, busy_b, done_b;
    int            total = 0;
    int            bad   = 0;

    bcd_digit_serializer_if #(.DIGITS_NUM(N)) ifa ();
    bcd_digit_serializer_if #(.DIGITS_NUM(N)) ifb ();

    assign ifa.digit_ready_in = ready;
    assign ifb.digit_ready_in = ready;

    bcd_digit_serializer #(.DIGITS_NUM(N), .BLANK_LEADING_ZEROS(1'b1)) dut_a (
        .clk_in(clk), .reset_in(reset), .start_in(start), .digits_in(digits),
        .overflow_in(ovf), .stream(ifa), .busy_out(busy_a), .done_out(done_a));

    bcd_digit_serializer #(.DIGITS_NUM(N), .BLANK_LEADING_ZEROS(1'b0)) dut_b (
        .clk_in(clk), .reset_in(reset), .start_in(start), .digits_in(digits),
        .overflow_in(ovf), .stream(ifb), .busy_out(busy_b), .done_out(done_b));

    always #5 clk = ~clk;

    // Reference: digit i of the value, substituted from the value's upper part.
    function automatic logic [3:0] model_digit(input logic [23:0] v, input bit o,
                                               input bit blank, input int i);
        logic [23:0] upper;
        upper = v >> (4 * i);
        if (o) return 4'hE;
        if (blank && i != 0 && upper == 24'd0) return 4'hF;
        return upper[3:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Runs one stream from IDLE; forces a 3-cycle stall when index stall_idx is shown.
    task automatic run_stream(input logic [23:0] val, input bit o, input int stall_pct,
                              input int stall_idx, input bit disturb);
        int k, cycles, stalls, held;
        bit rdy;
        digits = val; ovf = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = N - 1; cycles = 0; stalls = 0; held = 0;
        while (k >= 0 && cycles < 200) begin
            check("valid", 32'(ifa.digit_valid_out), 32'd1);
            check("busy", 32'(busy_a), 32'd1);
            check("digit", 32'(ifa.digit_out), 32'(model_digit(val, o, 1'b1, k)));
            check("index", 32'(ifa.digit_index_out), 32'(k));
            check("last", 32'(ifa.last_out), 32'(k == 0));
            check("digit_raw", 32'(ifb.digit_out), 32'(model_digit(val, o, 1'b0, k)));
            rdy = ($urandom_range(99) >= stall_pct);
            if (k == stall_idx && held < 3) begin
                rdy = 1'b0;
                held++;
            end
            if (!rdy) stalls++;
            ready = rdy;
            if (disturb) begin
                digits = $urandom;
                ovf    = 1'($urandom_range(1));
                start  = 1'($urandom_range(1));
            end
            @(posedge clk); #1;
            if (rdy) k--;
            cycles++;
        end
        $display("stream val=%06h ovf=%0d cycles=%0d stalls=%0d", val, o, cycles, stalls);
        check("stream_end", 32'(k), 32'hFFFF_FFFF);
        check("throughput", 32'(cycles), 32'(N + stalls));
        ready = 1'b1;
        start = disturb;
        check("done_pulse", 32'(done_a), 32'd1);
        check("done_busy", 32'(busy_a), 32'd1);
        check("done_valid", 32'(ifa.digit_valid_out), 32'd0);
        check("done_pulse_raw", 32'(done_b), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_once", 32'(done_a), 32'd0);
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_valid", 32'(ifa.digit_valid_out), 32'd0);
        check("idle_busy_raw", 32'(busy_b), 32'd0);
    endtask

    initial begin
        logic [23:0] rv;
        reset = 1'b1; start = 1'b0; ready = 1'b0; digits = '0; ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(ifa.digit_valid_out), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_digit", 32'(ifa.digit_out), 32'd0);
        check("rst_index", 32'(ifa.digit_index_out), 32'd0);
        check("rst_last", 32'(ifa.last_out), 32'd0);
        reset = 1'b0; ready = 1'b1;
        @(posedge clk); #1;

        run_stream(24'h001234, 1'b0, 0, -1, 1'b0);
        run_stream(24'h000000, 1'b0, 0, -1, 1'b0);
        run_stream(24'h105009, 1'b0, 0, 3, 1'b0);
        run_stream(24'h999999, 1'b1, 0, -1, 1'b0);
        run_stream(24'h000042, 1'b0, 0, -1, 1'b1);

        // Reset in the middle of a stream, after two transfers.
        digits = 24'h123456; ovf = 1'b0; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_index", 32'(ifa.digit_index_out), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", 32'(ifa.digit_valid_out), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_done", 32'(done_a), 32'd0);
        @(posedge clk); #1;
        check("post_rst_done", 32'(done_a), 32'd0);
        run_stream(24'h000007, 1'b0, 0, -1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            rv = 24'($urandom) >> (4 * $urandom_range(5));
            run_stream(rv, ($urandom_range(4) == 0), 30, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
